// File: rtl/key_entry_disp.sv
// Keypad entry buffer and multiplexed 7-segment display driver.
// Turns scanner key events into a BCD entry that is latched on ENTER.
module key_entry_disp #(
  parameter int unsigned N_DIG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pls1k,
  input  logic               nkpls,
  input  logic [4:0]         nkv,
  output logic [6:0]         seg,
  output logic [N_DIG-1:0]   dig_sel,
  output logic [4*N_DIG-1:0] val_out,
  output logic               val_vld,
  output logic               err,
  output logic [3:0]         dig_cnt
);

  localparam int unsigned PW = $clog2(N_DIG);
  localparam int unsigned BW = 4 * N_DIG;

  typedef enum logic [2:0] {
    KeyNone,
    KeyDigit,
    KeyClr,
    KeyDel,
    KeyEnter,
    KeyError
  } key_e;

  logic          np0, np1;
  logic          q0, q1;
  logic          key_ev;
  logic          disp_adv;
  logic [BW-1:0] buf_q;
  logic [PW-1:0] dptr_q;
  logic [PW-1:0] dptr_nxt;
  key_e          key_kind;
  logic [3:0]    key_dig;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  function automatic logic [6:0] bcd_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign key_ev   = np0 & ~np1;
  assign disp_adv = q0 & ~q1;

  always_comb begin
    key_kind = KeyNone;
    key_dig  = 4'h0;
    case (nkv)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        key_kind = KeyDigit;
        key_dig  = nkv[3:0];
      end
      5'd10:   key_kind = KeyDigit;
      5'd11:   key_kind = KeyClr;
      5'd12:   key_kind = KeyDel;
      5'd13:   key_kind = KeyEnter;
      5'd31:   key_kind = KeyError;
      default: key_kind = KeyNone;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      np0     <= 1'b0;
      np1     <= 1'b0;
      buf_q   <= '0;
      dig_cnt <= 4'd0;
      val_out <= '0;
      val_vld <= 1'b0;
      err     <= 1'b0;
    end else begin
      np0     <= nkpls;
      np1     <= np0;
      val_vld <= 1'b0;
      if (key_ev) begin
        case (key_kind)
          KeyDigit: begin
            // A full buffer silently drops further digits.
            if (dig_cnt < 4'(N_DIG)) begin
              buf_q   <= {buf_q[BW-5:0], key_dig};
              dig_cnt <= dig_cnt + 4'd1;
            end
            err <= 1'b0;
          end
          KeyClr: begin
            buf_q   <= '0;
            dig_cnt <= 4'd0;
            err     <= 1'b0;
          end
          KeyDel: begin
            if (dig_cnt != 4'd0) begin
              buf_q   <= {4'h0, buf_q[BW-1:4]};
              dig_cnt <= dig_cnt - 4'd1;
            end
            err <= 1'b0;
          end
          KeyEnter: begin
            val_out <= buf_q;
            val_vld <= 1'b1;
            buf_q   <= '0;
            dig_cnt <= 4'd0;
            err     <= 1'b0;
          end
          KeyError: begin
            err     <= 1'b1;
            buf_q   <= '0;
            dig_cnt <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  // Glyph is computed for the position being advanced to, so seg and
  // dig_sel change together on the advance clock.
  always_comb begin
    dptr_nxt = (dptr_q == PW'(N_DIG - 1)) ? '0 : dptr_q + PW'(1);
    nib      = buf_q[{dptr_nxt, 2'b00} +: 4];
    if (err) begin
      glyph = (dptr_nxt == '0) ? 7'h06 : 7'h7F;
    end else if (dig_cnt == 4'd0) begin
      glyph = (dptr_nxt == '0) ? bcd_seg(4'd0) : 7'h7F;
    end else if (4'(dptr_nxt) < dig_cnt) begin
      glyph = bcd_seg(nib);
    end else begin
      glyph = 7'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0      <= 1'b0;
      q1      <= 1'b0;
      dptr_q  <= '0;
      seg     <= 7'h7F;
      dig_sel <= '1;
    end else begin
      q0 <= pls1k;
      q1 <= q0;
      if (disp_adv) begin
        dptr_q  <= dptr_nxt;
        dig_sel <= ~(N_DIG'(1) << dptr_nxt);
        seg     <= glyph;
      end
    end
  end

endmodule

// File: tb/tb_key_entry_disp.sv
// Directed bench for key_entry_disp: key decode, entry buffer, ENTER latch
// and display scan, with expected values worked out by hand.
module tb_key_entry_disp;

  localparam int unsigned N_DIG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pls1k = 1'b0;
  logic        nkpls = 1'b0;
  logic [4:0]  nkv = 5'd0;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] val_out;
  logic        val_vld;
  logic        err;
  logic [3:0]  dig_cnt;

  int n_vec = 0;
  int n_err = 0;
  int tb_dptr = 0;

  key_entry_disp #(.N_DIG(N_DIG)) dut (
    .clk     (clk),
    .rst     (rst),
    .pls1k   (pls1k),
    .nkpls   (nkpls),
    .nkv     (nkv),
    .seg     (seg),
    .dig_sel (dig_sel),
    .val_out (val_out),
    .val_vld (val_vld),
    .err     (err),
    .dig_cnt (dig_cnt)
  );

  always #50 clk = ~clk;

  function automatic logic [3:0] exp_sel(input int pos);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << pos);
  endfunction

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    nkv   = k;
    nkpls = 1'b1;
    repeat (2) @(negedge clk);
    nkpls = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_1k();
    @(negedge clk);
    pls1k = 1'b1;
    @(negedge clk);
    pls1k = 1'b0;
    @(negedge clk);
    tb_dptr = (tb_dptr + 1) % N_DIG;
  endtask

  // Always advances at least once so seg reflects the current buffer.
  task automatic goto_pos(input int p);
    pulse_1k();
    for (int i = 0; i < N_DIG && tb_dptr != p; i++) pulse_1k();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_vec++; if (dig_sel !== 4'hF) begin n_err++; $display("FAIL reset_dig_sel got %h want f", dig_sel); end
    n_vec++; if (val_out !== 16'h0) begin n_err++; $display("FAIL reset_val_out got %h want 0", val_out); end
    n_vec++; if (val_vld !== 1'b0) begin n_err++; $display("FAIL reset_val_vld got %b want 0", val_vld); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL reset_dig_cnt got %0d want 0", dig_cnt); end
    rst = 1'b1;
    tb_dptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_digits();
    // Buffer 0x0123, cnt 3: pos0=3, pos1=2, pos2=1, pos3 blank.
    logic [6:0] exp_s [4];
    exp_s[0] = 7'h30; exp_s[1] = 7'h24; exp_s[2] = 7'h79; exp_s[3] = 7'h7F;
    press(5'd1); press(5'd2); press(5'd3);
    n_vec++; if (dig_cnt !== 4'd3) begin n_err++; $display("FAIL digits_cnt got %0d want 3", dig_cnt); end
    for (int i = 0; i < 4; i++) begin
      pulse_1k();
      n_vec++;
      if (dig_sel !== exp_sel(tb_dptr)) begin
        n_err++; $display("FAIL digits_sel pos %0d got %h want %h", tb_dptr, dig_sel, exp_sel(tb_dptr));
      end
      n_vec++;
      if (seg !== exp_s[tb_dptr]) begin
        n_err++; $display("FAIL digits_seg pos %0d got %h want %h", tb_dptr, seg, exp_s[tb_dptr]);
      end
    end
  endtask

  task automatic test_hold();
    press(5'd11);
    @(negedge clk);
    nkv   = 5'd5;
    nkpls = 1'b1;
    repeat (500) @(negedge clk);
    nkpls = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (dig_cnt !== 4'd1) begin n_err++; $display("FAIL hold_cnt got %0d want 1", dig_cnt); end
    goto_pos(0);
    n_vec++; if (seg !== 7'h12) begin n_err++; $display("FAIL hold_seg0 got %h want 12", seg); end
  endtask

  task automatic test_enter();
    int first;
    int n_hi;
    press(5'd11);
    press(5'd9); press(5'd8); press(5'd7); press(5'd6); press(5'd5);
    n_vec++; if (dig_cnt !== 4'd4) begin n_err++; $display("FAIL enter_full_cnt got %0d want 4", dig_cnt); end
    first = -1;
    n_hi  = 0;
    @(negedge clk);
    nkv   = 5'd13;
    nkpls = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (val_vld === 1'b1) begin
        n_hi++;
        if (first < 0) first = i;
      end
      if (i == 2) nkpls = 1'b0;
    end
    n_vec++; if (first !== 2) begin n_err++; $display("FAIL enter_vld_latency got %0d want 2", first); end
    n_vec++; if (n_hi !== 1) begin n_err++; $display("FAIL enter_vld_width got %0d want 1", n_hi); end
    n_vec++; if (val_out !== 16'h9876) begin n_err++; $display("FAIL enter_val_out got %h want 9876", val_out); end
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL enter_cnt got %0d want 0", dig_cnt); end
    goto_pos(0);
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL enter_seg0 got %h want 40", seg); end
    goto_pos(1);
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL enter_seg1 got %h want 7f", seg); end
  endtask

  task automatic test_error();
    press(5'd3);
    press(5'd31);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL error_err got %b want 1", err); end
    n_vec++; if (val_out !== 16'h9876) begin n_err++; $display("FAIL error_val_out got %h want 9876", val_out); end
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL error_cnt got %0d want 0", dig_cnt); end
    goto_pos(0);
    n_vec++; if (seg !== 7'h06) begin n_err++; $display("FAIL error_seg0 got %h want 06", seg); end
    goto_pos(1);
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL error_seg1 got %h want 7f", seg); end
    press(5'd7);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL error_clear got %b want 0", err); end
    n_vec++; if (dig_cnt !== 4'd1) begin n_err++; $display("FAIL error_next_cnt got %0d want 1", dig_cnt); end
    goto_pos(0);
    n_vec++; if (seg !== 7'h78) begin n_err++; $display("FAIL error_next_seg0 got %h want 78", seg); end
  endtask

  task automatic test_del();
    int n_hi;
    press(5'd11);
    press(5'd4); press(5'd2);
    n_vec++; if (dig_cnt !== 4'd2) begin n_err++; $display("FAIL del_cnt2 got %0d want 2", dig_cnt); end
    goto_pos(1);
    n_vec++; if (seg !== 7'h19) begin n_err++; $display("FAIL del_seg1_0042 got %h want 19", seg); end
    press(5'd12);
    n_vec++; if (dig_cnt !== 4'd1) begin n_err++; $display("FAIL del_cnt1 got %0d want 1", dig_cnt); end
    goto_pos(0);
    n_vec++; if (seg !== 7'h19) begin n_err++; $display("FAIL del_seg0_0004 got %h want 19", seg); end
    press(5'd12);
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL del_cnt0 got %0d want 0", dig_cnt); end
    press(5'd12);
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL del_noop_cnt got %0d want 0", dig_cnt); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL del_noop_err got %b want 0", err); end
    n_hi = 0;
    @(negedge clk);
    nkv   = 5'd13;
    nkpls = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (val_vld === 1'b1) n_hi++;
      if (i == 2) nkpls = 1'b0;
    end
    n_vec++; if (n_hi !== 1) begin n_err++; $display("FAIL del_enter_vld got %0d want 1", n_hi); end
    n_vec++; if (val_out !== 16'h0) begin n_err++; $display("FAIL del_enter_val got %h want 0", val_out); end
  endtask

  task automatic test_reset_mid();
    press(5'd5);
    press(5'd13);
    press(5'd6);
    pulse_1k();
    pulse_1k();
    @(negedge clk);
    nkv   = 5'd4;
    nkpls = 1'b1;
    pls1k = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (seg !== 7'h7F) begin n_err++; $display("FAIL mid_seg got %h want 7f", seg); end
    n_vec++; if (dig_sel !== 4'hF) begin n_err++; $display("FAIL mid_dig_sel got %h want f", dig_sel); end
    n_vec++; if (val_out !== 16'h0) begin n_err++; $display("FAIL mid_val_out got %h want 0", val_out); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err got %b want 0", err); end
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL mid_cnt got %0d want 0", dig_cnt); end
    nkpls = 1'b0;
    pls1k = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tb_dptr = 0;
    repeat (2) @(negedge clk);
    press(5'd14);
    press(5'd0);
    n_vec++; if (dig_cnt !== 4'd0) begin n_err++; $display("FAIL ignore_cnt got %0d want 0", dig_cnt); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL ignore_err got %b want 0", err); end
    n_vec++; if (val_out !== 16'h0) begin n_err++; $display("FAIL ignore_val got %h want 0", val_out); end
    n_vec++; if (dig_sel !== 4'hF) begin n_err++; $display("FAIL ignore_sel got %h want f", dig_sel); end
    press(5'd10);
    n_vec++; if (dig_cnt !== 4'd1) begin n_err++; $display("FAIL after_reset_cnt got %0d want 1", dig_cnt); end
    goto_pos(0);
    n_vec++; if (seg !== 7'h40) begin n_err++; $display("FAIL after_reset_seg0 got %h want 40", seg); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_hold();
    test_enter();
    test_error();
    test_del();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
